button_press_classifier: RTL and testbench
==========================================

// Module: button_press_classifier
// PURPOSE
//   Consumes the registered, debounced, active-high button levels from the debounce stage.
//   Turns each channel into one-cycle event pulses: short press, long press and,
//   optionally, double click. Sits between the debounce stage and the LED/mode control logic.
// PARAMETERS
//   NB          4           number of independent button channels
//   LONG_CYCLES 12_000_000  consecutive high samples needed for a long press (1 s @ 12 MHz); >=2
//   DBL_GAP     3_000_000   max low samples between release and re-press for a double click; >=2
//   CNT_W       24          width of each press counter; must hold LONG_CYCLES and DBL_GAP
// PORTS
//   CLK          in   1   system clock; all logic on posedge
//   RST          in   1   synchronous reset, active-high
//   btn_level    in   NB  debounced levels, 1 = pressed; already synchronous to CLK
//   short_pulse  out  NB  1-cycle pulse per channel: short press completed
//   long_pulse   out  NB  1-cycle pulse per channel: long threshold reached while held
//   dbl_pulse    out  NB  1-cycle pulse per channel: double click (constant 0 without macro)
//   held         out  NB  level: channel is in LONG state (long press still held)
// BEHAVIOUR
//   - One independent FSM plus CNT_W counter per channel; channels never interact.
//   - All outputs are registered; every pulse lasts exactly one cycle.
//   - Reset (RST=1 at an edge): every FSM -> WAIT_REL, counters=0, all outputs=0.
//     Reset mid-press discards the press; no pulse is emitted for it.
//   - States: WAIT_REL, IDLE, PRESS, LONG (+ GAP, PRESS2 with macro).
//   - WAIT_REL: level=0 -> IDLE. This blocks spurious events for a button held through reset.
//   - IDLE: level=1 -> PRESS, cnt<=1.
//   - PRESS, level=1:
//       cnt==LONG_CYCLES-1 -> long_pulse<=1, held<=1, LONG.
//       else cnt<=cnt+1.
//     The long pulse fires on the edge that samples the LONG_CYCLES-th consecutive high.
//   - PRESS, level=0:
//       no macro: short_pulse<=1, IDLE. Pulse is visible the cycle after the first low sample.
//       macro: GAP, cnt<=1.
//   - LONG: held=1 while level=1. Level=0 -> held<=0, IDLE; no pulse on release.
//   - Counter never wraps: it leaves PRESS or GAP on reaching its threshold.
//   - A press of exactly LONG_CYCLES-1 high samples is a short press.
//   - A 1-cycle high glitch is a short press. Filtering is the debounce stage's job.
// CONFIGURATION
//   Macro BTN_DBLCLICK_EN:
//   - Undefined: GAP and PRESS2 are not built; dbl_pulse tied to 0; short latency = 1 cycle.
//   - Defined:
//       GAP, level=0: cnt==DBL_GAP -> short_pulse<=1, IDLE; else cnt<=cnt+1.
//       GAP, level=1: PRESS2, cnt<=1. The first press is consumed; it emits no short_pulse.
//       PRESS2 uses the PRESS rules, except release -> dbl_pulse<=1, IDLE (no GAP).
//       PRESS2 reaching long -> long_pulse only, then LONG.
//       Short latency becomes DBL_GAP+1 cycles after the first low sample.
// TESTING
//   Bench uses NB=4, LONG_CYCLES=8, DBL_GAP=4.
//   1) RST 2 cycles, all levels 0, then 20 idle cycles
//      -> all outputs 0 throughout; no pulses.
//   2) ch0 high 3 cycles then low, no macro
//      -> short_pulse[0]=1 for exactly 1 cycle, 1 cycle after the first low sample.
//   3) ch1 high 7 cycles -> short only. ch1 high 20 cycles ->
//      long_pulse[1] on the edge sampling the 8th high; held[1]=1 until the first low
//      sample, then 0; no short pulse.
//   4) ch2 held high during and after RST, released after 10 cycles
//      -> no pulses at all. A later 3-cycle press gives a normal short pulse.
//   5) Macro on: ch3 high 2, low 2, high 2, low
//      -> dbl_pulse[3] once, no short_pulse.
//      Same sequence with a 6-cycle gap -> two short_pulses, no dbl_pulse.
//   6) ch0 and ch3 pressed on the same cycle with different lengths
//      -> independent, correctly timed pulses on each channel.
//      RST asserted mid-PRESS -> no pulse on either channel.

Source files
------------

// File: rtl/button_press_classifier.sv
// ---------------------------------------------------------------------------
// button_press_classifier
//   Turns debounced, active-high button levels into one-cycle event pulses
//   per channel: short press, long press and, when BTN_DBLCLICK_EN is
//   defined, double click. Each channel has its own FSM and press counter.
//   Channels never interact.
//
//   Optional feature macro: BTN_DBLCLICK_EN
//     undefined : no double-click detection, dbl_pulse tied to 0,
//                 short_pulse appears 1 cycle after the first low sample.
//     defined   : a release opens a gap window of DBL_GAP low samples; a
//                 re-press inside it becomes a double click, otherwise the
//                 short_pulse is emitted when the window closes.
//
// Ports
//   CLK          in   system clock, all logic on posedge
//   RST          in   synchronous reset, active-high
//   btn_level    in   [NB] debounced levels, 1 = pressed, synchronous to CLK
//   short_pulse  out  [NB] 1-cycle pulse: short press completed
//   long_pulse   out  [NB] 1-cycle pulse: long threshold reached while held
//   dbl_pulse    out  [NB] 1-cycle pulse: double click
//   held         out  [NB] level: channel is in LONG (long press still held)
//
// State  | meaning
// -------+------------------------------------------------------------------
// WAIT_REL | after reset; wait for a low level before accepting a press
// IDLE     | released, waiting for a press
// PRESS    | first press in progress, cnt = high samples so far
// LONG     | long threshold reached, button still held
// GAP      | (macro) released after a short press, cnt = low samples so far
// PRESS2   | (macro) second press of a possible double click
// ---------------------------------------------------------------------------
module button_press_classifier #(
  parameter int NB          = 4,
  parameter int LONG_CYCLES = 12_000_000,
  parameter int DBL_GAP     = 3_000_000,
  parameter int CNT_W       = 24
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [NB-1:0] btn_level,
  output logic [NB-1:0] short_pulse,
  output logic [NB-1:0] long_pulse,
  output logic [NB-1:0] dbl_pulse,
  output logic [NB-1:0] held
);

  // Elaboration-time sanity check on the counter sizing.
  if (LONG_CYCLES < 2 || DBL_GAP < 2 ||
      (longint'(LONG_CYCLES) >> CNT_W) != 0 ||
      (longint'(DBL_GAP) >> CNT_W) != 0) begin : g_bad_params
    $error("button_press_classifier: LONG_CYCLES/DBL_GAP must be >= 2 and fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BTN_DBLCLICK_EN
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(DBL_GAP);

  typedef enum logic [2:0] {
    WAIT_REL,
    IDLE,
    PRESS,
    LONG,
    GAP,
    PRESS2
  } state_t;
`else
  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    PRESS,
    LONG
  } state_t;
`endif

  for (genvar i = 0; i < NB; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             short_r;
    logic             long_r;
    logic             held_r;
`ifdef BTN_DBLCLICK_EN
    logic             dbl_r;
`endif

    always_ff @(posedge CLK) begin
      if (RST) begin
        state   <= WAIT_REL;
        cnt     <= '0;
        short_r <= 1'b0;
        long_r  <= 1'b0;
        held_r  <= 1'b0;
`ifdef BTN_DBLCLICK_EN
        dbl_r   <= 1'b0;
`endif
      end else begin
        // pulses default low so each one lasts exactly one cycle
        short_r <= 1'b0;
        long_r  <= 1'b0;
`ifdef BTN_DBLCLICK_EN
        dbl_r   <= 1'b0;
`endif
        case (state)
          WAIT_REL: begin
            // a button held through reset must be released before it counts
            if (!btn_level[i]) state <= IDLE;
          end
          IDLE: begin
            if (btn_level[i]) begin
              state <= PRESS;
              cnt   <= CNT_ONE;
            end
          end
`ifdef BTN_DBLCLICK_EN
          PRESS, PRESS2: begin
`else
          PRESS: begin
`endif
            if (btn_level[i]) begin
              if (cnt == LONG_TC) begin
                long_r <= 1'b1;
                held_r <= 1'b1;
                state  <= LONG;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
`ifdef BTN_DBLCLICK_EN
              if (state == PRESS2) begin
                dbl_r <= 1'b1;
                state <= IDLE;
              end else begin
                state <= GAP;
                cnt   <= CNT_ONE;
              end
`else
              short_r <= 1'b1;
              state   <= IDLE;
`endif
            end
          end
          LONG: begin
            // release after a long press is silent
            if (!btn_level[i]) begin
              held_r <= 1'b0;
              state  <= IDLE;
            end
          end
`ifdef BTN_DBLCLICK_EN
          GAP: begin
            if (btn_level[i]) begin
              // first press is absorbed into the double click
              state <= PRESS2;
              cnt   <= CNT_ONE;
            end else if (cnt == GAP_TC) begin
              short_r <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
`endif
          default: state <= WAIT_REL;
        endcase
      end
    end

    assign short_pulse[i] = short_r;
    assign long_pulse[i]  = long_r;
    assign held[i]        = held_r;
`ifdef BTN_DBLCLICK_EN
    assign dbl_pulse[i]   = dbl_r;
`else
    assign dbl_pulse[i]   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_button_press_classifier
//   Directed bench for button_press_classifier with NB=4, LONG_CYCLES=8,
//   DBL_GAP=4. Works with or without BTN_DBLCLICK_EN; expected short-press
//   timing follows the build (SL = low samples up to and including the edge
//   that raises short_pulse).
// ---------------------------------------------------------------------------
module tb_button_press_classifier;

  localparam int NB          = 4;
  localparam int LONG_CYCLES = 8;
  localparam int DBL_GAP     = 4;
  localparam int CNT_W       = 24;

`ifdef BTN_DBLCLICK_EN
  localparam int SL = DBL_GAP + 1;
`else
  localparam int SL = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] short_pulse;
  logic [NB-1:0] long_pulse;
  logic [NB-1:0] dbl_pulse;
  logic [NB-1:0] held;

  int n_checks = 0;
  int n_fail   = 0;

  button_press_classifier #(
    .NB          (NB),
    .LONG_CYCLES (LONG_CYCLES),
    .DBL_GAP     (DBL_GAP),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .btn_level   (btn_level),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .dbl_pulse   (dbl_pulse),
    .held        (held)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NB-1:0] lvl;
    int            n;
    logic [NB-1:0] s;
    logic [NB-1:0] l;
    logic [NB-1:0] h;
    logic [NB-1:0] d;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [NB-1:0] lvl, input int n,
                              input logic [NB-1:0] s, input logic [NB-1:0] l,
                              input logic [NB-1:0] h, input logic [NB-1:0] d);
    vec_t v;
    v.lvl = lvl; v.n = n; v.s = s; v.l = l; v.h = h; v.d = d;
    vecs.push_back(v);
  endfunction

  // drive inputs, advance one edge, sample 1 time unit later
  task automatic step(input logic [NB-1:0] lvl);
    btn_level = lvl;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [NB-1:0] es,
                       input logic [NB-1:0] el, input logic [NB-1:0] eh,
                       input logic [NB-1:0] ed);
    n_checks++;
    if (short_pulse !== es || long_pulse !== el || held !== eh || dbl_pulse !== ed) begin
      n_fail++;
      $display("FAIL %s: got short=%b long=%b held=%b dbl=%b, expected short=%b long=%b held=%b dbl=%b",
               name, short_pulse, long_pulse, held, dbl_pulse, es, el, eh, ed);
    end
  endtask

  initial begin
    logic [NB-1:0] es, el, eh, ed, lvl;

    // ---------------- reset ----------------
    RST = 1'b1;
    btn_level = '0;
    for (int k = 0; k < 2; k++) begin
      step(4'b0000);
      check($sformatf("reset_%0d", k), '0, '0, '0, '0);
    end
    RST = 1'b0;

    // ---------------- table-driven part ----------------
    // idle stretch
    add(4'b0000, 20, '0, '0, '0, '0);
    // ch0: 3-cycle press -> short
    add(4'b0001, 3, '0, '0, '0, '0);
    add(4'b0000, SL - 1, '0, '0, '0, '0);
    add(4'b0000, 1, 4'b0001, '0, '0, '0);
    add(4'b0000, 2, '0, '0, '0, '0);
    // ch1: LONG_CYCLES-1 highs is still a short press
    add(4'b0010, 7, '0, '0, '0, '0);
    add(4'b0000, SL - 1, '0, '0, '0, '0);
    add(4'b0000, 1, 4'b0010, '0, '0, '0);
    add(4'b0000, 2, '0, '0, '0, '0);
    // ch1: 20 highs -> long on the 8th, held until first low, no short
    add(4'b0010, 7, '0, '0, '0, '0);
    add(4'b0010, 1, '0, 4'b0010, 4'b0010, '0);
    add(4'b0010, 12, '0, '0, 4'b0010, '0);
    add(4'b0000, 1, '0, '0, '0, '0);
    add(4'b0000, SL + 3, '0, '0, '0, '0);

    for (int v = 0; v < vecs.size(); v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        step(vecs[v].lvl);
        check($sformatf("vec%0d_cyc%0d", v, k), vecs[v].s, vecs[v].l, vecs[v].h, vecs[v].d);
      end
    end

    // ---------------- ch2 held through reset ----------------
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(4'b0100);
      check($sformatf("hold_rst_%0d", k), '0, '0, '0, '0);
    end
    RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(4'b0100);
      check($sformatf("hold_after_rst_%0d", k), '0, '0, '0, '0);
    end
    for (int t = 1; t <= 15; t++) begin
      step(4'b0000);
      check($sformatf("hold_release_%0d", t), '0, '0, '0, '0);
    end
    // later normal 3-cycle press
    for (int t = 1; t <= 13; t++) begin
      step((t <= 3) ? 4'b0100 : 4'b0000);
      es = (t == 3 + SL) ? 4'b0100 : 4'b0000;
      check($sformatf("ch2_short_t%0d", t), es, '0, '0, '0);
    end

    // ---------------- ch3: high 2, low 2, high 2, low ----------------
    for (int t = 1; t <= 15; t++) begin
      lvl = (t <= 2 || t == 5 || t == 6) ? 4'b1000 : 4'b0000;
      step(lvl);
`ifdef BTN_DBLCLICK_EN
      es = '0;
      ed = (t == 7) ? 4'b1000 : 4'b0000;
`else
      es = (t == 3 || t == 7) ? 4'b1000 : 4'b0000;
      ed = '0;
`endif
      check($sformatf("dbl_gap2_t%0d", t), es, '0, '0, ed);
    end

    // ---------------- ch3: high 2, low 6, high 2, low ----------------
    for (int t = 1; t <= 20; t++) begin
      lvl = (t <= 2 || t == 9 || t == 10) ? 4'b1000 : 4'b0000;
      step(lvl);
      es = (t == 3 + SL - 1 || t == 11 + SL - 1) ? 4'b1000 : 4'b0000;
      check($sformatf("dbl_gap6_t%0d", t), es, '0, '0, '0);
    end

    // ---------------- ch0 short + ch3 long, same start cycle ----------------
    for (int t = 1; t <= 20; t++) begin
      lvl = {(t <= 9), 2'b00, (t <= 3)};
      step(lvl);
      es = (t == 3 + SL) ? 4'b0001 : 4'b0000;
      el = (t == 8) ? 4'b1000 : 4'b0000;
      eh = (t == 8 || t == 9) ? 4'b1000 : 4'b0000;
      ed = '0;
      check($sformatf("multi_t%0d", t), es, el, eh, ed);
    end

    // ---------------- reset in the middle of PRESS ----------------
    for (int t = 1; t <= 3; t++) begin
      step(4'b1001);
      check($sformatf("midrst_press_t%0d", t), '0, '0, '0, '0);
    end
    RST = 1'b1;
    step(4'b1001);
    check("midrst_reset", '0, '0, '0, '0);
    RST = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      step(4'b0000);
      check($sformatf("midrst_after_t%0d", t), '0, '0, '0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
